pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
- Parametrised pipeline register for any stage boundary (decode/execute, execute/memory, memory/writeback).
- Carries a flat payload with a valid/ready handshake and a 2-entry skid buffer, so upstream stall timing is decoupled from downstream.
- Supports flush-to-bubble, with a per-bit keep mask selecting which payload fields survive a flush.
- Replaces hand-written per-stage register banks with one block instantiated per stage.

Parameters:
- DATA_WIDTH, 64: payload width in bits (instruction word plus control fields, packed by the instantiating stage).
- BUBBLE_DATA, {DATA_WIDTH{1'b0}}: payload value presented while the stage holds no valid entry. NOP_INSTRUCTION sits in its instruction field.
- KEEP_MASK, {DATA_WIDTH{1'b0}}: bits set to 1 keep the last loaded value across flush/bubble; bits at 0 take BUBBLE_DATA.
- SKID_EN_DEPTH, 2: entries (1 = plain register, no skid; 2 = main + skid). Only 1 and 2 are legal.

Ports:
- clk  in  1  clock; all state updates on negedge clk, as for every pipeline register in the core.
- rst_n  in  1  reset; synchronous, active-low.
- in_valid  in  1  upstream offers payload.
- in_ready  out  1  stage can accept; registered.
- in_data  in  DATA_WIDTH  upstream payload.
- flush  in  1  discard all held entries and drop any same-edge input.
- out_valid  out  1  head entry valid.
- out_ready  in  1  downstream accepts.
- out_data  out  DATA_WIDTH  head payload, or bubble composite when out_valid=0.
- out_is_bubble  out  1  equals ~out_valid; provided for hazard logic.
- occupancy  out  2  number of held entries, 0..SKID_EN_DEPTH.

Behaviour:
- Transfer definitions: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready. Both are sampled at negedge clk.
- Reset (rst_n=0 at an edge):
  - main_valid=0, skid_valid=0, occupancy=0.
  - main_data=BUBBLE_DATA, skid_data=BUBBLE_DATA.
  - in_ready=0 while rst_n=0; in_ready=1 at the first edge with rst_n=1.
- Reset beats flush; flush beats everything else.
- Flush: at the edge, both valids clear and occupancy=0; in_ready=1 after the edge.
  - main_data = (main_data & KEEP_MASK) | (BUBBLE_DATA & ~KEEP_MASK).
  - An in_fire in the same cycle is dropped.
- out_data (combinational):
  - main_valid=1: main_data.
  - main_valid=0: (main_data & KEEP_MASK) | (BUBBLE_DATA & ~KEEP_MASK).
- Depth 2 transitions, with state = occupancy:
  - 0, in_fire: main<=in, occ=1.
  - 1, in_fire & out_fire: main<=in, occ=1.
  - 1, in_fire & ~out_fire: skid<=in, occ=2, in_ready<=0.
  - 1, ~in_fire & out_fire: main_valid<=0, occ=0; main_data is retained for the keep fields.
  - 2, out_fire: main<=skid, skid_valid<=0, occ=1, in_ready<=1.
  - 2, no in_fire is possible (in_ready=0).
- Depth 1: in_ready = ~main_valid | out_ready. This single path is combinational; no skid entry exists.
- Latency: in_fire to out_valid is one edge. Throughput is one entry per cycle with out_ready held high.
- Ordering: strictly FIFO; payloads are never duplicated or reordered.
- Protocol: upstream must hold in_data stable while in_valid & ~in_ready. If out_valid=1 and out_ready=0, out_data must not change.

Optional Feature:
- Macro PIPE_STAGE_PERF_CNT_EN.
- Defined:
  - Adds outputs stall_cycles and bubble_cycles, both 32 bits and saturating.
  - stall_cycles increments each edge where out_valid & ~out_ready.
  - bubble_cycles increments each edge where ~out_valid & out_ready.
  - Both clear on reset and on flush.
- Undefined: the ports and counters are absent; everything else is unchanged.

Decomposition:
- Shared package pipe_pkg holds:
  - NOP_INSTRUCTION.
  - Field offset/width localparams for packing the decode/execute payload (rm0, instruction, dest reg, operands, cu_* bits, src/dst address, offset).
  - The default KEEP_MASK for decode/execute: alu_op, alu_src, is_imm, is_byte_op, src/dst address, offset, rm0.
- One natural sub-module: pipe_skid_entry, a single valid+data register with load/clear/keep-mask. It is instantiated twice.

Test Plan (DATA_WIDTH=64, BUBBLE_DATA=64'h13, KEEP_MASK=64'hFF00; "reset" = rst_n low 2 edges, then high):
- Reset then idle -> out_valid=0, occupancy=0, out_data=64'h13, in_ready=1 one edge after rst_n rises.
- Stream 0xA1..0xA8, one per cycle, out_ready=1 -> outputs appear 1 edge later in order; in_ready stays 1; occupancy stays ≤1.
- Load 0xB1 with out_ready=0, then offer 0xB2 -> occupancy=2, in_ready=0. Raise out_ready -> 0xB1 then 0xB2, with no loss or duplicate.
- Hold 64'hABCD with occupancy=1, assert flush together with in_valid of 64'h5555 -> out_valid=0, out_data=64'hAB13, 0x5555 never appears.
- Assert rst_n=0 with occupancy=2 -> next edge occupancy=0, in_ready=0. Under PIPE_STAGE_PERF_CNT_EN: 5 cycles of out_valid & ~out_ready give stall_cycles=5, and a flush returns it to 0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared constants and decode/execute payload layout for pipe_stage_reg.
// Optional perf counters in pipe_stage_reg: PIPE_STAGE_PERF_CNT_EN.
package pipe_pkg;

    localparam logic [31:0] NOP_INSTRUCTION = 32'h0000_0013;

    localparam int OCC_W = 2;

    // Decode/execute payload field layout (LSB offset, width)
    localparam int DE_RM0_LSB     = 0;
    localparam int DE_RM0_W       = 1;
    localparam int DE_ALU_OP_LSB  = 1;
    localparam int DE_ALU_OP_W    = 4;
    localparam int DE_ALU_SRC_LSB = 5;
    localparam int DE_IS_IMM_LSB  = 6;
    localparam int DE_IS_BYTE_LSB = 7;
    localparam int DE_CU_LSB      = 8;
    localparam int DE_CU_W        = 3;
    localparam int DE_DEST_LSB    = 11;
    localparam int DE_DEST_W      = 5;
    localparam int DE_SRC_LSB     = 16;
    localparam int DE_SRC_W       = 8;
    localparam int DE_DST_LSB     = 24;
    localparam int DE_DST_W       = 8;
    localparam int DE_OFF_LSB     = 32;
    localparam int DE_OFF_W       = 12;
    localparam int DE_INSTR_LSB   = 44;
    localparam int DE_INSTR_W     = 32;
    localparam int DE_OPA_LSB     = 76;
    localparam int DE_OPB_LSB     = 108;
    localparam int DE_OPND_W      = 32;
    localparam int DE_WIDTH       = 140;

    // Fields that survive a flush in the decode/execute register
    function automatic logic [DE_WIDTH-1:0] de_keep_mask();
        logic [DE_WIDTH-1:0] m;
        m = '0;
        m[DE_RM0_LSB +: DE_RM0_W]       = '1;
        m[DE_ALU_OP_LSB +: DE_ALU_OP_W] = '1;
        m[DE_ALU_SRC_LSB]               = 1'b1;
        m[DE_IS_IMM_LSB]                = 1'b1;
        m[DE_IS_BYTE_LSB]               = 1'b1;
        m[DE_SRC_LSB +: DE_SRC_W]       = '1;
        m[DE_DST_LSB +: DE_DST_W]       = '1;
        m[DE_OFF_LSB +: DE_OFF_W]       = '1;
        return m;
    endfunction

    localparam logic [DE_WIDTH-1:0] DE_KEEP_MASK = de_keep_mask();

endpackage

// File: rtl/pipe_skid_entry.sv
// One valid+data entry with load, drop and keep-masked flush.
// Presents the keep/bubble composite whenever the entry is empty.
module pipe_skid_entry
    import pipe_pkg::*;
#(
    parameter int                    W      = 64,
    parameter logic [W-1:0]          BUBBLE = '0,
    parameter logic [W-1:0]          KEEP   = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_flush,
    input  logic         i_load,
    input  logic [W-1:0] i_data,
    input  logic         i_drop,
    output logic         o_valid,
    output logic [W-1:0] o_data
);

    logic         r_valid;
    logic [W-1:0] r_data;
    logic [W-1:0] w_keep;

    assign w_keep  = (r_data & KEEP) | (BUBBLE & ~KEEP);
    assign o_valid = r_valid;
    assign o_data  = r_valid ? r_data : w_keep;

    // Entry update: reset, then flush, then load, then drop
    always_ff @(negedge clk) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= BUBBLE;
        end else if (i_flush) begin
            r_valid <= 1'b0;
            r_data  <= w_keep;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end else if (i_drop) begin
            r_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake and optional skid.
// Optional stall/bubble counters: PIPE_STAGE_PERF_CNT_EN.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int                     DATA_WIDTH    = 64,
    parameter logic [DATA_WIDTH-1:0]  BUBBLE_DATA   = '0,
    parameter logic [DATA_WIDTH-1:0]  KEEP_MASK     = '0,
    parameter int                     SKID_EN_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_is_bubble,
    output logic [OCC_W-1:0]      occupancy
`ifdef PIPE_STAGE_PERF_CNT_EN
    ,
    output logic [31:0]           stall_cycles,
    output logic [31:0]           bubble_cycles
`endif
);

    logic                  r_in_ready;
    logic                  w_in_ready;
    logic                  w_main_valid;
    logic                  w_skid_valid;
    logic [DATA_WIDTH-1:0] w_main_data;
    logic [DATA_WIDTH-1:0] w_skid_data;
    logic                  w_in_fire;
    logic                  w_out_fire;
    logic                  w_occ0;
    logic                  w_occ1;
    logic                  w_occ2;
    logic                  w_main_load;
    logic                  w_main_drop;
    logic [DATA_WIDTH-1:0] w_main_din;
    logic                  w_skid_load;
    logic                  w_skid_drop;
    logic                  w_full_next;

    // Depth 1 passes downstream ready straight through; depth 2 is registered
    assign w_in_ready = (SKID_EN_DEPTH == 2) ? r_in_ready
                      : (r_in_ready & (~w_main_valid | out_ready));

    assign w_in_fire  = in_valid & w_in_ready;
    assign w_out_fire = w_main_valid & out_ready;

    assign w_occ0 = ~w_main_valid;
    assign w_occ1 = w_main_valid & ~w_skid_valid;
    assign w_occ2 = w_skid_valid;

    assign w_main_load = (w_in_fire & (w_occ0 | w_out_fire)) |
                         (w_occ2 & w_out_fire);
    assign w_main_din  = w_occ2 ? w_skid_data : in_data;
    assign w_main_drop = w_occ1 & ~w_in_fire & w_out_fire;

    assign w_skid_load = (SKID_EN_DEPTH == 2) &
                         w_occ1 & w_in_fire & ~w_out_fire;
    assign w_skid_drop = w_occ2 & w_out_fire;

    assign w_full_next = w_occ2 ? ~w_out_fire : w_skid_load;

    pipe_skid_entry #(
        .W      (DATA_WIDTH),
        .BUBBLE (BUBBLE_DATA),
        .KEEP   (KEEP_MASK)
    ) u_main (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_flush (flush),
        .i_load  (w_main_load),
        .i_data  (w_main_din),
        .i_drop  (w_main_drop),
        .o_valid (w_main_valid),
        .o_data  (w_main_data)
    );

    pipe_skid_entry #(
        .W      (DATA_WIDTH),
        .BUBBLE (BUBBLE_DATA),
        .KEEP   (KEEP_MASK)
    ) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_flush (flush),
        .i_load  (w_skid_load),
        .i_data  (in_data),
        .i_drop  (w_skid_drop),
        .o_valid (w_skid_valid),
        .o_data  (w_skid_data)
    );

    // Ready drops only while both entries are held
    always_ff @(negedge clk) begin
        if (!rst_n) begin
            r_in_ready <= 1'b0;
        end else if (flush) begin
            r_in_ready <= 1'b1;
        end else begin
            r_in_ready <= ~w_full_next;
        end
    end

    assign in_ready      = w_in_ready;
    assign out_valid     = w_main_valid;
    assign out_data      = w_main_data;
    assign out_is_bubble = ~w_main_valid;
    assign occupancy     = {w_skid_valid, w_main_valid & ~w_skid_valid};

`ifdef PIPE_STAGE_PERF_CNT_EN
    logic [31:0] r_stall;
    logic [31:0] r_bubble;

    // Saturating stall/bubble counters, cleared by reset or flush
    always_ff @(negedge clk) begin
        if (!rst_n || flush) begin
            r_stall  <= '0;
            r_bubble <= '0;
        end else begin
            if (w_main_valid && !out_ready && !(&r_stall))
                r_stall <= r_stall + 32'd1;
            if (!w_main_valid && out_ready && !(&r_bubble))
                r_bubble <= r_bubble + 32'd1;
        end
    end

    assign stall_cycles  = r_stall;
    assign bubble_cycles = r_bubble;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg against a queue-based model.
// Also checks the perf counters when PIPE_STAGE_PERF_CNT_EN is defined.
module tb_pipe_stage_reg;

    localparam int          W = 64;
    localparam logic [63:0] B = 64'h13;
    localparam logic [63:0] K = 64'hFF00;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic        out_is_bubble;
    logic [1:0]  occupancy;
`ifdef PIPE_STAGE_PERF_CNT_EN
    logic [31:0] stall_cycles;
    logic [31:0] bubble_cycles;
`endif

    always #5 clk = ~clk;

    pipe_stage_reg #(
        .DATA_WIDTH    (W),
        .BUBBLE_DATA   (B),
        .KEEP_MASK     (K),
        .SKID_EN_DEPTH (2)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .flush         (flush),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_is_bubble (out_is_bubble),
        .occupancy     (occupancy)
`ifdef PIPE_STAGE_PERF_CNT_EN
        ,
        .stall_cycles  (stall_cycles),
        .bubble_cycles (bubble_cycles)
`endif
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: FIFO contents, ready flag, last head payload, counters
    logic [63:0] m_q[$];
    logic        m_rdy  = 1'b0;
    logic [63:0] m_last = 64'h13;
    logic [31:0] m_stall  = 0;
    logic [31:0] m_bubble = 0;

    function automatic logic [63:0] keepf(input logic [63:0] x);
        return (x & K) | (B & ~K);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [63:0] exp_d;
        exp_d = (m_q.size() > 0) ? m_q[0] : keepf(m_last);
        chk("occupancy", 64'(occupancy), 64'(m_q.size()));
        chk("out_valid", 64'(out_valid), 64'(m_q.size() > 0));
        chk("out_bubble", 64'(out_is_bubble), 64'(m_q.size() == 0));
        chk("out_data", out_data, exp_d);
        chk("in_ready", 64'(in_ready), 64'(m_rdy));
`ifdef PIPE_STAGE_PERF_CNT_EN
        chk("stall_cnt", 64'(stall_cycles), 64'(m_stall));
        chk("bubble_cnt", 64'(bubble_cycles), 64'(m_bubble));
`endif
    endtask

    // One clock: drive inputs, model the edge, then sample mid-cycle
    task automatic step(input logic rn, input logic iv, input logic [63:0] d,
                        input logic ordy, input logic fl);
        logic ifire, ofire, ov;
        rst_n = rn; in_valid = iv; in_data = d;
        out_ready = ordy; flush = fl;
        ov    = m_q.size() > 0;
        ifire = iv & m_rdy;
        ofire = ov & ordy;
        @(negedge clk);
        if (!rn) begin
            m_q.delete(); m_rdy = 1'b0; m_last = B;
            m_stall = 0; m_bubble = 0;
        end else if (fl) begin
            m_q.delete(); m_rdy = 1'b1; m_last = keepf(m_last);
            m_stall = 0; m_bubble = 0;
        end else begin
            if (ov && !ordy && m_stall != 32'hFFFF_FFFF) m_stall++;
            if (!ov && ordy && m_bubble != 32'hFFFF_FFFF) m_bubble++;
            if (ofire) void'(m_q.pop_front());
            if (ifire) m_q.push_back(d);
            if (m_q.size() > 0) m_last = m_q[0];
            m_rdy = m_q.size() < 2;
        end
        @(posedge clk);
        check_all();
    endtask

    initial begin
        logic        iv;
        logic [63:0] d;
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0;
        flush = 1'b0; out_ready = 1'b0;

        // Reset for two edges, then release
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        step(1, 0, 0, 0, 0);
        chk("idle_data", out_data, 64'h13);

        // Stream A1..A8 at full rate
        for (int i = 1; i <= 8; i++) begin
            step(1, 1, 64'hA0 + 64'(i), 1, 0);
            chk("stream_head", out_data, 64'hA0 + 64'(i));
        end
        step(1, 0, 0, 1, 0);

        // Fill both entries, then drain in order
        step(1, 1, 64'hB1, 0, 0);
        step(1, 1, 64'hB2, 0, 0);
        chk("full_occ", 64'(occupancy), 64'd2);
        chk("full_rdy", 64'(in_ready), 64'd0);
        step(1, 0, 0, 1, 0);
        chk("drain_b2", out_data, 64'hB2);
        step(1, 0, 0, 1, 0);
        step(1, 0, 0, 1, 0);

        // Flush with a same-edge input; keep field survives
        step(1, 1, 64'hABCD, 0, 0);
        step(1, 1, 64'h5555, 0, 1);
        chk("flush_data", out_data, 64'hAB13);
        step(1, 0, 0, 1, 0);
        chk("flush_nodup", out_data, 64'hAB13);

        // Reset while full
        step(1, 1, 64'hC1, 0, 0);
        step(1, 1, 64'hC2, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("rst_full_occ", 64'(occupancy), 64'd0);
        step(1, 0, 0, 0, 0);

        // Five stall edges, then flush clears the counter
        step(1, 1, 64'hD1, 0, 0);
        for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0);
`ifdef PIPE_STAGE_PERF_CNT_EN
        chk("stall_5", 64'(stall_cycles), 64'd5);
`endif
        step(1, 0, 0, 0, 1);
`ifdef PIPE_STAGE_PERF_CNT_EN
        chk("stall_clr", 64'(stall_cycles), 64'd0);
`endif

        // Random traffic respecting the hold rule upstream
        iv = 1'b0; d = '0;
        for (int i = 0; i < 400; i++) begin
            if (!(iv && !m_rdy)) begin
                iv = 1'($urandom_range(0, 1));
                d  = {$urandom, $urandom};
            end
            step(1, iv, d, 1'($urandom_range(0, 2) != 0),
                 $urandom_range(0, 40) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
